// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings and default widths for the instruction/data SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int ARB_ADDR_WD = 32;
  localparam int ARB_DATA_WD = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  // Owner encoding; also the bit position of each side in the arbiter request vector.
  localparam logic ARB_INST = 1'b0;
  localparam logic ARB_DATA = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side that was not last served.
module arb_rr2
  import sram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = ARB_INST;
    if (req == 2'b11) gnt = ~last;
    else if (req[ARB_DATA]) gnt = ARB_DATA;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the fetch and MEM-stage requesters, one transaction at a time.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WD = ARB_ADDR_WD,
  parameter int DATA_WD = ARB_DATA_WD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_req,
  input  logic                 inst_wr,
  input  logic [1:0]           inst_size,
  input  logic [ADDR_WD-1:0]   inst_addr,
  input  logic [DATA_WD-1:0]   inst_wdata,
  input  logic [DATA_WD/8-1:0] inst_wstrb,
  output logic                 inst_addr_ok,
  output logic                 inst_data_ok,
  output logic [DATA_WD-1:0]   inst_rdata,
  input  logic                 data_req,
  input  logic                 data_wr,
  input  logic [1:0]           data_size,
  input  logic [ADDR_WD-1:0]   data_addr,
  input  logic [DATA_WD-1:0]   data_wdata,
  input  logic [DATA_WD/8-1:0] data_wstrb,
  output logic                 data_addr_ok,
  output logic                 data_data_ok,
  output logic [DATA_WD-1:0]   data_rdata,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [1:0]           mem_size,
  output logic [ADDR_WD-1:0]   mem_addr,
  output logic [DATA_WD-1:0]   mem_wdata,
  output logic [DATA_WD/8-1:0] mem_wstrb,
  input  logic                 mem_addr_ok,
  input  logic                 mem_data_ok,
  input  logic [DATA_WD-1:0]   mem_rdata,
  output logic [1:0]           dbg_state
);

  arb_state_e state;
  logic       owner;
  logic       last_owner;
  logic       gnt;
  logic       sel;
  logic       addr_acc;
  logic       resp_done;

  arb_rr2 u_arb_rr2 (
    .req  ({data_req, inst_req}),
    .last (last_owner),
    .gnt  (gnt)
  );

  // Only IDLE consults the arbiter; once a request is latched the grant is frozen in owner.
  assign sel = (state == ARB_IDLE) ? gnt : owner;

  always_comb begin
    mem_req = 1'b0;
    case (state)
      ARB_IDLE: mem_req = inst_req | data_req;
      ARB_HOLD: mem_req = 1'b1;
      default:  mem_req = 1'b0;
    endcase
  end

  always_comb begin
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    mem_wstrb = inst_wstrb;
    if (sel == ARB_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_wstrb = data_wstrb;
    end
  end

  // mem_req is already low in WAIT, so a stray mem_addr_ok there is dropped.
  assign addr_acc  = mem_req & mem_addr_ok;
  assign resp_done = (state == ARB_WAIT) & mem_data_ok;

  assign inst_addr_ok = addr_acc & (sel == ARB_INST);
  assign data_addr_ok = addr_acc & (sel == ARB_DATA);
  assign inst_data_ok = resp_done & (owner == ARB_INST);
  assign data_data_ok = resp_done & (owner == ARB_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= ARB_INST;
      last_owner <= ARB_INST;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (addr_acc) begin
            owner      <= gnt;
            last_owner <= gnt;
            state      <= ARB_WAIT;
          end else if (mem_req) begin
            owner <= gnt;
            state <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (mem_addr_ok) begin
            last_owner <= owner;
            state      <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_data_ok) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: hand-computed expectations checked with immediate assertions.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_HOLD = 32'd1;
  localparam logic [31:0] S_WAIT = 32'd2;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_wstrb(inst_wstrb),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin : stim
    logic [3:0] rr_seq;
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h111; inst_wdata = 0; inst_wstrb = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h222; data_wdata = 0; data_wstrb = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    tick();
    do_reset();

    // Reset state, idle outputs follow the inst side
    settle();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_mem_addr", mem_addr, 32'h111);
    chk("rst_state", dbg_state, S_IDLE);

    // Single inst read
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    settle();
    chk("t1_c0_mem_req", mem_req, 1);
    chk("t1_c0_mem_addr", mem_addr, 32'h1c000000);
    chk("t1_c0_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_c0_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    settle();
    chk("t1_c1_state", dbg_state, S_WAIT);
    chk("t1_c1_mem_req", mem_req, 0);
    chk("t1_c1_inst_data_ok", inst_data_ok, 0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'h02800c21;
    settle();
    chk("t1_c2_inst_data_ok", inst_data_ok, 1);
    chk("t1_c2_inst_rdata", inst_rdata, 32'h02800c21);
    chk("t1_c2_data_data_ok", data_data_ok, 0);
    chk("t1_c2_data_addr_ok", data_addr_ok, 0);
    tick();
    mem_data_ok = 0;
    settle();
    chk("t1_end_state", dbg_state, S_IDLE);

    // Tie after reset: data first, inst at next IDLE
    do_reset();
    inst_req = 1; inst_addr = 32'h1c000010;
    data_req = 1; data_addr = 32'h00000080;
    mem_addr_ok = 1;
    settle();
    chk("t2_tie_data_addr_ok", data_addr_ok, 1);
    chk("t2_tie_inst_addr_ok", inst_addr_ok, 0);
    chk("t2_tie_mem_addr", mem_addr, 32'h00000080);
    tick();
    data_req = 0; mem_data_ok = 1; mem_rdata = 32'hcafe0001;
    settle();
    chk("t2_wait_mem_req", mem_req, 0);
    chk("t2_wait_inst_addr_ok", inst_addr_ok, 0);
    chk("t2_data_data_ok", data_data_ok, 1);
    chk("t2_data_rdata", data_rdata, 32'hcafe0001);
    chk("t2_inst_data_ok_quiet", inst_data_ok, 0);
    tick();
    mem_data_ok = 0;
    settle();
    chk("t2_inst_addr_ok", inst_addr_ok, 1);
    chk("t2_inst_mem_addr", mem_addr, 32'h1c000010);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    settle();
    chk("t2_inst_data_ok", inst_data_ok, 1);
    chk("t2_data_data_ok_quiet", data_data_ok, 0);
    tick();
    mem_data_ok = 0;

    // HOLD lock on a data write while inst arrives
    data_req = 1; data_wr = 1; data_addr = 32'h00000040; data_wstrb = 4'hf; data_wdata = 32'h12345678;
    mem_addr_ok = 0;
    settle();
    chk("t3_c0_mem_req", mem_req, 1);
    chk("t3_c0_mem_addr", mem_addr, 32'h40);
    chk("t3_c0_mem_wr", mem_wr, 1);
    chk("t3_c0_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 1; inst_wr = 0; inst_addr = 32'h1c000100;
    settle();
    chk("t3_c1_state", dbg_state, S_HOLD);
    chk("t3_c1_mem_addr", mem_addr, 32'h40);
    chk("t3_c1_mem_wr", mem_wr, 1);
    chk("t3_c1_mem_wdata", mem_wdata, 32'h12345678);
    chk("t3_c1_inst_addr_ok", inst_addr_ok, 0);
    tick();
    settle();
    chk("t3_c2_mem_addr", mem_addr, 32'h40);
    chk("t3_c2_mem_req", mem_req, 1);
    tick();
    mem_addr_ok = 1;
    settle();
    chk("t3_c3_data_addr_ok", data_addr_ok, 1);
    chk("t3_c3_inst_addr_ok", inst_addr_ok, 0);
    chk("t3_c3_mem_wstrb", mem_wstrb, 4'hf);
    tick();
    data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1;
    settle();
    chk("t3_c4_data_data_ok", data_data_ok, 1);
    chk("t3_c4_mem_req_blocked", mem_req, 0);
    chk("t3_c4_inst_addr_ok", inst_addr_ok, 0);
    tick();
    mem_data_ok = 0; mem_addr_ok = 1;
    settle();
    chk("t3_c5_inst_addr_ok", inst_addr_ok, 1);
    chk("t3_c5_mem_addr", mem_addr, 32'h1c000100);
    chk("t3_c5_mem_wr", mem_wr, 0);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    settle();
    chk("t3_c6_inst_data_ok", inst_data_ok, 1);
    tick();
    mem_data_ok = 0;

    // Round-robin under continuous contention; last served was inst, so D,I,D,I
    rr_seq = 4'b0101;
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      mem_data_ok = 0;
      settle();
      chk($sformatf("t4_rr%0d_data_addr_ok", i), data_addr_ok, rr_seq[i]);
      chk($sformatf("t4_rr%0d_inst_addr_ok", i), inst_addr_ok, !rr_seq[i]);
      tick();
      mem_data_ok = 1;
      settle();
      chk($sformatf("t4_rr%0d_data_data_ok", i), data_data_ok, rr_seq[i]);
      chk($sformatf("t4_rr%0d_inst_data_ok", i), inst_data_ok, !rr_seq[i]);
      tick();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    tick();

    // Reset mid-WAIT abandons the transaction
    inst_req = 1; inst_addr = 32'h1c000200; mem_addr_ok = 1;
    settle();
    chk("t5_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    settle();
    chk("t5_state_wait", dbg_state, S_WAIT);
    reset = 1;
    tick();
    reset = 0; mem_data_ok = 1;
    settle();
    chk("t5_inst_data_ok", inst_data_ok, 0);
    chk("t5_data_data_ok", data_data_ok, 0);
    chk("t5_mem_req", mem_req, 0);
    chk("t5_state", dbg_state, S_IDLE);
    tick();
    mem_data_ok = 0;

    // Spurious mem_data_ok / mem_addr_ok while idle
    mem_data_ok = 1; mem_addr_ok = 1; mem_rdata = 32'hdeadbeef;
    settle();
    chk("t6_idle_inst_data_ok", inst_data_ok, 0);
    chk("t6_idle_data_data_ok", data_data_ok, 0);
    chk("t6_idle_inst_addr_ok", inst_addr_ok, 0);
    chk("t6_idle_data_addr_ok", data_addr_ok, 0);
    tick();
    settle();
    chk("t6_idle_state", dbg_state, S_IDLE);
    mem_data_ok = 0; mem_addr_ok = 0;

    // Spurious mem_data_ok while holding a data read
    data_req = 1; data_addr = 32'h00000100;
    tick();
    mem_data_ok = 1;
    settle();
    chk("t6_hold_data_data_ok", data_data_ok, 0);
    chk("t6_hold_state", dbg_state, S_HOLD);
    tick();
    settle();
    chk("t6_hold_stays", dbg_state, S_HOLD);
    mem_data_ok = 0; mem_addr_ok = 1;
    settle();
    chk("t6_hold_data_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    settle();
    chk("t6_hold_done", data_data_ok, 1);
    tick();
    mem_data_ok = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
